vitals_tracker: RTL and testbench



---
 rtl/vitals_tracker.sv | 136 +++++++++++++
 tb/tb_vitals_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vitals_tracker.sv
// Pet vital meters (fullness/energy/happiness) advanced once per prescaled tick.
// Optional age-based death is built only when VITALS_AGE_EN is defined.

module vitals_meter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         dec,
  input  logic [1:0]   mag,
  output logic [W-1:0] val,
  output logic [W-1:0] nxt
);
  logic [W:0] sum;

  // W+1 bit sum so the increment can be clamped before it wraps
  always_comb begin
    sum = {1'b0, val} + {{(W-1){1'b0}}, mag};
    nxt = val;
    if (adv) begin
      if (dec) nxt = (val >= W'(mag)) ? val - W'(mag) : '0;
      else     nxt = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   val <= W'(MAX);
    else if (adv) val <= nxt;
  end
endmodule

module vitals_tracker #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int W         = 4,
  parameter int MAX       = 15,
  parameter int LIMIAR    = 3,
  parameter int IDADE_W   = 8,
  parameter int IDADE_MAX = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         estado,
  output logic [W-1:0]       saciedade,
  output logic [W-1:0]       energia,
  output logic [W-1:0]       alegria,
  output logic               aviso,
  output logic               morreu,
  output logic [IDADE_W-1:0] idade
);
  localparam int NM = 3;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [3:0] ST_IDLE = 4'd0, ST_DORM = 4'd1, ST_COME = 4'd2,
                         ST_AULA = 4'd3, ST_MORTO = 4'd4;

  if (TICK_DIV < 2 || MAX > 2**W-1 || IDADE_MAX > 2**IDADE_W-1) begin : g_bad_cfg
    $error("vitals_tracker: bad parameter combination");
  end

  logic [PW-1:0]          cnt;
  logic                   tick, adv, age_death;
  logic [NM-1:0]          dec, low, zero;
  logic [NM-1:0][1:0]     mag;
  logic [NM-1:0][W-1:0]   val, nxt;

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == PW'(TICK_DIV-1));
  assign adv  = tick && !morreu && (estado != ST_MORTO);

  // index 0 saciedade, 1 energia, 2 alegria; unknown codes behave as IDLE
  always_comb begin
    dec = 3'b111;
    mag = {2'd1, 2'd1, 2'd1};
    case (estado)
      ST_DORM: begin dec = 3'b001; mag = {2'd0, 2'd2, 2'd1}; end
      ST_COME: begin dec = 3'b110; mag = {2'd1, 2'd1, 2'd2}; end
      ST_AULA: begin dec = 3'b011; mag = {2'd2, 2'd2, 2'd1}; end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < NM; gi++) begin : g_meter
    vitals_meter #(.W(W), .MAX(MAX)) u_meter (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  (adv),
      .dec  (dec[gi]),
      .mag  (mag[gi]),
      .val  (val[gi]),
      .nxt  (nxt[gi])
    );
    assign low[gi]  = (nxt[gi] <= W'(LIMIAR));
    assign zero[gi] = (nxt[gi] == '0);
  end

  assign saciedade = val[0];
  assign energia   = val[1];
  assign alegria   = val[2];

`ifdef VITALS_AGE_EN
  logic [IDADE_W-1:0] idade_r, idade_nxt;

  always_comb begin
    idade_nxt = idade_r;
    if (adv && idade_r != '1) idade_nxt = idade_r + 1'b1;
  end

  assign age_death = (idade_nxt == IDADE_W'(IDADE_MAX));
  assign idade     = idade_r;

  always_ff @(posedge clk) begin
    if (!rst_n)   idade_r <= '0;
    else if (adv) idade_r <= idade_nxt;
  end
`else
  assign age_death = 1'b0;
  assign idade     = '0;
`endif

  // flags follow the next-state meters so they move on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aviso  <= 1'b0;
      morreu <= 1'b0;
    end else if (tick) begin
      aviso  <= |low;
      morreu <= morreu | (|zero) | age_death;
    end
  end
endmodule

// File: tb/tb_vitals_tracker.sv
// Scoreboard bench for vitals_tracker: expected vitals queued per tick, popped after the tick edge.
module tb_vitals_tracker;
  localparam int TD = 4;
`ifdef VITALS_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] estado = 4'd0;
  logic [3:0] saciedade, energia, alegria;
  logic       aviso, morreu;
  logic [7:0] idade;

  vitals_tracker #(.TICK_DIV(TD), .W(4), .MAX(15), .LIMIAR(3), .IDADE_W(8), .IDADE_MAX(6)) dut (
    .clk(clk), .rst_n(rst_n), .estado(estado), .saciedade(saciedade), .energia(energia),
    .alegria(alegria), .aviso(aviso), .morreu(morreu), .idade(idade)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sac, en, al;
    bit aviso, morreu;
    int idade;
  } vit_t;

  vit_t q[$];
  vit_t m;
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampv(int v);
    return (v < 0) ? 0 : ((v > 15) ? 15 : v);
  endfunction

  function automatic vit_t model_next(vit_t c, logic [3:0] e);
    vit_t n = c;
    int ds = -1, de = -1, da = -1;
    if (!c.morreu && e != 4'd4) begin
      case (e)
        4'd1: begin ds = -1; de =  2; da =  0; end
        4'd2: begin ds =  2; de = -1; da = -1; end
        4'd3: begin ds = -1; de = -2; da =  2; end
        default: ;
      endcase
      n.sac = clampv(c.sac + ds);
      n.en  = clampv(c.en + de);
      n.al  = clampv(c.al + da);
      if (AGE_EN) n.idade = (c.idade < 255) ? c.idade + 1 : 255;
    end
    n.aviso  = (n.sac <= 3) || (n.en <= 3) || (n.al <= 3);
    n.morreu = c.morreu || n.sac == 0 || n.en == 0 || n.al == 0 || (AGE_EN && n.idade == 6);
    return n;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    vit_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got output with no expectation", tag);
    end else begin
      e = q.pop_front();
      check({tag, ".sac"},    int'(saciedade), e.sac);
      check({tag, ".en"},     int'(energia),   e.en);
      check({tag, ".al"},     int'(alegria),   e.al);
      check({tag, ".aviso"},  int'(aviso),     int'(e.aviso));
      check({tag, ".morreu"}, int'(morreu),    int'(e.morreu));
      check({tag, ".idade"},  int'(idade),     e.idade);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m = '{sac: 15, en: 15, al: 15, aviso: 1'b0, morreu: 1'b0, idade: 0};
    q.push_back(m);
    cyc(2);
    pop_chk(tag);
    rst_n = 1'b1;
  endtask

  // one full tick period; meters must hold until the TD-th edge
  task automatic tick(input logic [3:0] e, input string tag);
    int prev_sac = m.sac;
    estado = e;
    m = model_next(m, e);
    q.push_back(m);
    cyc(TD - 1);
    check({tag, ".hold"}, int'(saciedade), prev_sac);
    cyc(1);
    pop_chk(tag);
  endtask

  task automatic ticks(input logic [3:0] e, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(e, tag);
  endtask

  initial begin
    do_reset("rst");
    tick(4'd0, "first");
    check("first.lit", int'(saciedade), 14);

    ticks(4'd0, 3, "idle4");
    tick(4'd2, "come1");
    check("come1.lit_s", int'(saciedade), 13);
    check("come1.lit_e", int'(energia), 10);
    tick(4'd2, "come_sat");
    check("come_sat.lit", int'(saciedade), 15);

    do_reset("rst2");
    ticks(4'd0, 12, "idle12");
`ifndef VITALS_AGE_EN
    check("idle12.lit_al", int'(alegria), 3);
    check("idle12.lit_av", int'(aviso), 1);
`endif
    tick(4'd1, "dorm");
`ifndef VITALS_AGE_EN
    check("dorm.lit_e", int'(energia), 5);
`endif

    do_reset("rst3");
    ticks(4'd0, 15, "idle15");
`ifndef VITALS_AGE_EN
    check("idle15.lit_m", int'(morreu), 1);
`endif
    tick(4'd4, "morto");
    ticks(4'd0, 2, "dead_idle");
    check("dead_idle.lit", int'(saciedade), 0);

    // reset landing mid-period at prescaler count 2
    do_reset("rst4");
    tick(4'd3, "aula");
    estado = 4'd3;
    cyc(2);
    rst_n = 1'b0;
    m = '{sac: 15, en: 15, al: 15, aviso: 1'b0, morreu: 1'b0, idade: 0};
    q.push_back(m);
    cyc(1);
    pop_chk("midrst");
    rst_n = 1'b1;
    tick(4'd3, "aula2");
    check("aula2.lit_e", int'(energia), 13);

    do_reset("rst5");
    for (int i = 0; i < 3; i++) begin
      tick(4'd1, "alt_d");
      tick(4'd2, "alt_c");
    end
    check("age.lit_i", int'(idade), AGE_EN ? 6 : 0);
    check("age.lit_m", int'(morreu), AGE_EN ? 1 : 0);
    check("age.lit_al", int'(alegria), 12);

    // estado change mid-period: only the value present at the tick counts
    do_reset("rst6");
    estado = 4'd2;
    cyc(2);
    estado = 4'd3;
    m = model_next(m, 4'd3);
    q.push_back(m);
    cyc(TD - 2);
    pop_chk("midchg");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
